mem_wb_stage: RTL

Memory/writeback stage directly downstream of the datapath function unit. It accepts one instruction per handshake: the function-unit result and flags, opcode, destination register, and the load/store address and data. ALU-class results go straight to the register-file write port. LD/ST run a request/grant/response transaction on the data-memory port, and load data is written back when it returns. The stage also holds the architectural status register (V, C, N, Z).

---
 rtl/mem_wb_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires ALU/SLT results to the register file, runs
// LD/ST request/grant/response transactions, and holds the {V,C,N,Z} status.

package mem_wb_pkg;

  // Shared ISA opcode encodings (7-bit)
  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_SUB  = 7'h05;
  localparam logic [6:0] OP_AND  = 7'h08;
  localparam logic [6:0] OP_OR   = 7'h09;
  localparam logic [6:0] OP_XOR  = 7'h0A;
  localparam logic [6:0] OP_NOT  = 7'h0B;
  localparam logic [6:0] OP_MOVB = 7'h0C;
  localparam logic [6:0] OP_LSR  = 7'h0D;
  localparam logic [6:0] OP_LSL  = 7'h0E;
  localparam logic [6:0] OP_LD   = 7'h10;
  localparam logic [6:0] OP_ST   = 7'h20;
  localparam logic [6:0] OP_MOVA = 7'h40;
  localparam logic [6:0] OP_ADI  = 7'h42;
  localparam logic [6:0] OP_SBI  = 7'h45;
  localparam logic [6:0] OP_ANI  = 7'h48;
  localparam logic [6:0] OP_ORI  = 7'h49;
  localparam logic [6:0] OP_XRI  = 7'h4A;
  localparam logic [6:0] OP_AIU  = 7'h52;
  localparam logic [6:0] OP_SIU  = 7'h55;
  localparam logic [6:0] OP_BZ   = 7'h60;
  localparam logic [6:0] OP_BNZ  = 7'h61;
  localparam logic [6:0] OP_SLT  = 7'h65;
  localparam logic [6:0] OP_JMP  = 7'h70;
  localparam logic [6:0] OP_JML  = 7'h71;
  localparam logic [6:0] OP_JMR  = 7'h72;

  // Bit positions inside the {V, C, N, Z} flag vector
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 1;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_SLT,
    CLS_LD,
    CLS_ST
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_MOVA, OP_MOVB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU,
      OP_LSL, OP_LSR:                                  cls = CLS_ALU;
      OP_SLT:                                          cls = CLS_SLT;
      OP_LD:                                           cls = CLS_LD;
      OP_ST:                                           cls = CLS_ST;
      OP_NOP, OP_BZ, OP_BNZ, OP_JMP, OP_JML, OP_JMR:   cls = CLS_NONE;
      default:                                         cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [DATA_W-1:0] in_fout,
  input  logic [3:0]        in_flags,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_sdata,
  input  logic [REG_AW-1:0] in_dr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [REG_AW-1:0]   dr_q,        dr_d;
  logic                wb_en_q,     wb_en_d;
  logic [REG_AW-1:0]   wb_addr_q,   wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q,   wb_data_d;
  logic [3:0]          status_q,    status_d;

  op_class_e           in_class;
  logic                accept;
  logic                slt_bit;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_class = classify(in_opcode);
  assign slt_bit  = in_flags[FLAG_N] ^ in_flags[FLAG_V];

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dr_d        = dr_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (in_class)
            CLS_ALU: begin
              status_d = in_flags;
              // R0 is hardwired zero, so its writes are dropped
              if (in_dr != '0) begin
                wb_en_d   = 1'b1;
                wb_addr_d = in_dr;
                wb_data_d = in_fout;
              end
            end
            CLS_SLT: begin
              status_d = in_flags;
              if (in_dr != '0) begin
                wb_en_d   = 1'b1;
                wb_addr_d = in_dr;
                wb_data_d = {{(DATA_W-1){1'b0}}, slt_bit};
              end
            end
            CLS_LD, CLS_ST: begin
              mem_req_d   = 1'b1;
              mem_we_d    = (in_class == CLS_ST);
              mem_addr_d  = in_addr;
              mem_wdata_d = in_sdata;
              dr_d        = in_dr;
              state_d     = S_REQ;
            end
            default: ;
          endcase
        end
      end

      S_REQ: begin
        // Request fields stay frozen until the grant; rvalid before it is ignored
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = S_IDLE;
          end else if (mem_rvalid) begin
            wb_en_d   = (dr_q != '0);
            wb_addr_d = (dr_q != '0) ? dr_q : wb_addr_q;
            wb_data_d = (dr_q != '0) ? mem_rdata : wb_data_q;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          wb_en_d   = (dr_q != '0);
          wb_addr_d = (dr_q != '0) ? dr_q : wb_addr_q;
          wb_data_d = (dr_q != '0) ? mem_rdata : wb_data_q;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dr_q        <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      status_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its _d input regardless of statement order.
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dr_q        <= dr_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      status_q    <= status_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign status    = status_q;

endmodule
